// File: rtl/multicycle_mem_responder_if.sv
// Request/response bus between the multicycle CPU and its memory responder.
// The CPU side drives the level-held request; the memory side answers with ready/data/error.
interface multicycle_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  mem_ready;
    logic                  mem_busy;
    logic                  mem_err;

    modport master (
        output mem_read, mem_write, addr, din,
        input  dout, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, din,
        output dout, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency word memory answering a level-held read/write request with a 4-phase handshake.
// The request is latched at the sampling edge; the access happens LATENCY edges later.
module multicycle_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16384,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_mem_responder_if.slave    bus
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int MEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [MEM_W-1:0]      idx_lat;
    logic [DATA_WIDTH-1:0] din_lat;
    logic                  wr_lat;
    logic                  err_lat;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ready_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             req;
    logic             req_err;
    logic             access;
    logic             mem_we;
    logic [IDX_W-1:0] idx_in;

    assign req     = bus.mem_read | bus.mem_write;
    assign idx_in  = bus.addr[ADDR_WIDTH-1:2];
    // Errors are decided at the sampling edge so later addr changes cannot affect them.
    assign req_err = (|bus.addr[1:0]) | (idx_in >= IDX_W'(DEPTH)) | (bus.mem_read & bus.mem_write);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        unique case (state)
            IDLE: if (req) state_next = BUSY;
            BUSY: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_we = access & wr_lat & ~err_lat & ~reset;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_lat <= '0;
            din_lat <= '0;
            wr_lat  <= 1'b0;
            err_lat <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx_lat <= idx_in[MEM_W-1:0];
                        din_lat <= bus.din;
                        wr_lat  <= bus.mem_write;
                        err_lat <= req_err;
                        cnt     <= CNT_W'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (req && cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (access) begin
                        ready_q <= 1'b1;
                        err_q   <= err_lat;
                        dout_q  <= (wr_lat || err_lat) ? '0 : mem[idx_lat];
                    end
                end
                DONE: begin
                    if (!req) begin
                        ready_q <= 1'b0;
                        dout_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the backing array has no reset; its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_lat] <= din_lat;
    end

    assign bus.dout      = dout_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_busy  = (state == BUSY);
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed scoreboard bench: one responder at LATENCY=4 and one at LATENCY=1.
// Expected responses are queued when a request is driven and compared when mem_ready rises.
module tb_multicycle_mem_responder;
    localparam int DEPTH = 16384;

    logic clk;
    logic rst4;
    logic rst1;

    multicycle_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus4 ();
    multicycle_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

    multicycle_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(4)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4.slave)
    );

    multicycle_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus4.mem_read = rd; bus4.mem_write = wr; bus4.addr = a; bus4.din = d;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.din = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus4.mem_ready : bus1.mem_ready;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus4.mem_busy : bus1.mem_busy;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus4.mem_err : bus1.mem_err;
    endfunction
    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 0) ? bus4.dout : bus1.dout;
    endfunction

    // One full handshake: drive, optionally move addr/din during BUSY, wait for ready,
    // hold the request in DONE, then drop it and check the response clears.
    task automatic transact(input int sel, input string tag, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_dout, input logic exp_err,
                            input int hold, input bit move_addr, input logic [31:0] alt_addr);
        int   n;
        exp_t e;
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        sb.push_back('{tag, exp_dout, exp_err});
        @(posedge clk);
        @(negedge clk);
        check({tag, " busy"}, 64'(get_busy(sel)), 64'd1);
        if (move_addr) drive(sel, rd, wr, alt_addr, ~d);
        n = 0;
        while (!get_ready(sel) && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'((sel == 0) ? 4 : 1));
        e = sb.pop_front();
        check({e.tag, " dout"}, 64'(get_dout(sel)), 64'(e.dout));
        check({e.tag, " err"}, 64'(get_err(sel)), 64'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {31'd0, get_ready(sel), get_dout(sel)}, {31'd0, 1'b1, e.dout});
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, " release"},
              {29'd0, get_ready(sel), get_busy(sel), get_err(sel), get_dout(sel)}, 64'd0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst4 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        rst1 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle4", {29'd0, bus4.mem_ready, bus4.mem_busy, bus4.mem_err, bus4.dout}, 64'd0);
        end

        transact(0, "wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "wr44", 1'b0, 1'b1, 32'h44, 32'h0BADF00D, 32'h0, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "rd40_move", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 32'h44);
        transact(0, "rd44", 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "wr_misalign", 1'b0, 1'b1, 32'h42, 32'h11111111, 32'h0, 1'b1, 0, 1'b0, 32'h0);
        transact(0, "rd40_after", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "rd_oor", 1'b1, 1'b0, DEPTH * 4, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0);
        transact(0, "rd_wr_both", 1'b1, 1'b1, 32'h44, 32'h22222222, 32'h0, 1'b1, 0, 1'b0, 32'h0);
        transact(0, "rd44_after", 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 0, 1'b0, 32'h0);
        transact(0, "wr80", 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b0, 32'h0);

        // Reset arrives two edges after the write is sampled; the write must be abandoned.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        check("abort reset", {30'd0, bus4.mem_ready, bus4.mem_busy, bus4.dout}, 64'd0);
        repeat (6) @(negedge clk);
        check("abort idle", {30'd0, bus4.mem_ready, bus4.mem_busy, bus4.dout}, 64'd0);
        transact(0, "rd80_after_abort", 1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle1", {29'd0, bus1.mem_ready, bus1.mem_busy, bus1.mem_err, bus1.dout}, 64'd0);
        end
        transact(1, "l1_wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0, 32'h0);
        transact(1, "l1_rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0);
        transact(1, "l1_rd_misalign", 1'b1, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0);

        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
